// File: rtl/inv_shift_rows_stream.sv
// Byte-serial AES state collector applying InvShiftRows (or ShiftRows when FWD_MODE=1).
// Result is valid 1 cycle after the 16th byte; in_ready drops only while a finished block waits for the output slot.
module inv_shift_rows_stream #(
    parameter bit FWD_MODE = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_byte,
    input  logic         in_flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    logic [3:0]   cnt;
    logic [127:0] asm_reg;
    logic         asm_full;
    logic [127:0] merged;
    logic         slot_free;
    logic         accept;

    // Byte i = row i%4, column i/4, stored MSB-first.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        int           sc;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sc = FWD_MODE ? ((c + r) % 4) : ((c - r + 4) % 4);
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*sc) -: 8];
            end
        end
        return o;
    endfunction

    assign in_ready  = !asm_full;
    assign slot_free = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign busy      = (cnt != 4'd0) || asm_full || out_valid;

    // Bit offset of byte cnt is 8*(15-cnt), i.e. {~cnt, 3'b000}.
    always_comb begin
        merged = asm_reg;
        merged[{~cnt, 3'b000} +: 8] = in_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            asm_reg   <= '0;
            asm_full  <= 1'b0;
            out_valid <= 1'b0;
            out_state <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (in_flush) begin
                cnt      <= '0;
                asm_full <= 1'b0;
            end else if (asm_full) begin
                if (slot_free) begin
                    out_state <= shift_rows(asm_reg);
                    out_valid <= 1'b1;
                    asm_full  <= 1'b0;
                end
            end else if (accept) begin
                asm_reg <= merged;
                cnt     <= cnt + 4'd1;
                if (cnt == 4'hF) begin
                    if (slot_free) begin
                        out_state <= shift_rows(merged);
                        out_valid <= 1'b1;
                    end else begin
                        asm_full <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
